// File: rtl/multi_phasor_if.sv
// Bundles the control inputs and beat outputs of the multi-voice phase accumulator.
// The master side (stimulus or a host) drives ticks, FM, writes and retriggers.
// The slave side (multi_phasor) drives sweep status and the registered output beat.
interface multi_phasor_if #(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = 32,
  parameter int ADDR_W     = 12
);
  localparam int VW = $clog2(NUM_VOICES);
  localparam int IW = PHASE_W - ADDR_W;

  logic               sample_tick;
  logic [PHASE_W-1:0] fm_in;
  logic               wr_en;
  logic [VW-1:0]      wr_voice;
  logic [PHASE_W-1:0] wr_inc;
  logic [1:0]         wr_mode;
  logic               trig_en;
  logic [VW-1:0]      trig_voice;
  logic               busy;
  logic [VW-1:0]      sweep_voice;
  logic               out_valid;
  logic [VW-1:0]      out_voice;
  logic [ADDR_W-1:0]  wavetableAddr;
  logic [IW-1:0]      interp;
  logic               out_wrap;
  logic               out_active;
  logic               overrun;

  modport master (
    output sample_tick, fm_in, wr_en, wr_voice, wr_inc, wr_mode, trig_en, trig_voice,
    input  busy, sweep_voice, out_valid, out_voice, wavetableAddr, interp,
           out_wrap, out_active, overrun
  );

  modport slave (
    input  sample_tick, fm_in, wr_en, wr_voice, wr_inc, wr_mode, trig_en, trig_voice,
    output busy, sweep_voice, out_valid, out_voice, wavetableAddr, interp,
           out_wrap, out_active, overrun
  );
endinterface

// File: rtl/multi_phasor.sv
// Time-multiplexed phase accumulators: one voice updated per cycle during a sweep.
// Latency: beat for voice v is registered one cycle after sweep_voice==v.
// No backpressure: a sample_tick during a sweep is dropped and flags overrun.
module multi_phasor #(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = 32,
  parameter int ADDR_W     = 12
) (
  input  logic           Clk,
  input  logic           Reset,
  multi_phasor_if.slave  bus
);
  localparam int VW = $clog2(NUM_VOICES);
  localparam int IW = PHASE_W - ADDR_W;
  localparam logic [VW-1:0] LAST_VOICE = VW'(NUM_VOICES - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SWEEP = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [VW-1:0]      r_cnt;
  logic               w_busy;

  logic [PHASE_W-1:0] r_phase [NUM_VOICES];
  logic [PHASE_W-1:0] r_inc   [NUM_VOICES];
  logic [1:0]         r_mode  [NUM_VOICES];
  logic               r_active      [NUM_VOICES];
  logic               r_trig_pending[NUM_VOICES];
  logic               r_prev_wrap;

  logic               r_out_valid;
  logic [VW-1:0]      r_out_voice;
  logic [PHASE_W-1:0] r_out_phase;
  logic               r_out_wrap;
  logic               r_out_active;
  logic               r_overrun;

  logic signed [PHASE_W:0] w_eff;
  logic [PHASE_W-1:0] w_cur;
  logic [PHASE_W-1:0] w_nxt;
  logic               w_wrap_raw;
  logic [PHASE_W-1:0] w_new_phase;
  logic [PHASE_W-1:0] w_out_phase;
  logic               w_out_wrap;
  logic               w_new_active;

  // State register and voice counter; counter parks at 0 outside a sweep.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_SWEEP && r_cnt != LAST_VOICE) r_cnt <= r_cnt + 1'b1;
      else                                           r_cnt <= '0;
    end
  end

  // Next state: a tick opens a sweep, the last voice closes it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.sample_tick)       w_state_nxt = S_SWEEP;
      S_SWEEP: if (r_cnt == LAST_VOICE)   w_state_nxt = S_IDLE;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: busy only while sweeping.
  always_comb begin
    w_busy = (r_state == S_SWEEP);
  end

  assign w_cur      = r_phase[r_cnt];
  assign w_eff      = $signed({1'b0, r_inc[r_cnt]}) + $signed({bus.fm_in[PHASE_W-1], bus.fm_in});
  assign w_nxt      = w_cur + w_eff[PHASE_W-1:0];
  assign w_wrap_raw = w_eff[PHASE_W] ? (w_nxt > w_cur) : (w_nxt < w_cur);

  // Per-voice update: pending trigger beats everything, stopped one-shots hold 0.
  always_comb begin
    w_new_phase  = w_nxt;
    w_out_phase  = w_cur;
    w_out_wrap   = w_wrap_raw;
    w_new_active = r_active[r_cnt];
    if (r_trig_pending[r_cnt]) begin
      w_out_phase  = '0;
      w_out_wrap   = 1'b0;
      w_new_phase  = w_eff[PHASE_W-1:0];
      w_new_active = 1'b1;
    end else if (!r_active[r_cnt]) begin
      w_out_phase  = '0;
      w_out_wrap   = 1'b0;
      w_new_phase  = '0;
    end else if (r_mode[r_cnt] == 2'd1 && w_wrap_raw) begin
      w_new_phase  = '0;
      w_new_active = 1'b0;
    end else if (r_mode[r_cnt] == 2'd2 && r_cnt != '0 && r_prev_wrap) begin
      w_new_phase  = '0;
    end
  end

  // Voice storage; host writes/triggers land after the sweep update so they win.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_phase[i]        <= '0;
        r_inc[i]          <= '0;
        r_mode[i]         <= 2'd0;
        r_active[i]       <= 1'b1;
        r_trig_pending[i] <= 1'b0;
      end
      r_prev_wrap <= 1'b0;
    end else begin
      r_prev_wrap <= w_busy ? w_out_wrap : 1'b0;
      if (w_busy) begin
        r_phase[r_cnt]        <= w_new_phase;
        r_active[r_cnt]       <= w_new_active;
        r_trig_pending[r_cnt] <= 1'b0;
      end
      if (bus.wr_en) begin
        r_inc[bus.wr_voice]  <= bus.wr_inc;
        r_mode[bus.wr_voice] <= bus.wr_mode;
        if (bus.wr_mode != 2'd1) r_active[bus.wr_voice] <= 1'b1;
      end
      if (bus.trig_en) r_trig_pending[bus.trig_voice] <= 1'b1;
    end
  end

  // Output beat register; payload holds its value between beats.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_out_valid  <= 1'b0;
      r_out_voice  <= '0;
      r_out_phase  <= '0;
      r_out_wrap   <= 1'b0;
      r_out_active <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_out_valid <= w_busy;
      if (w_busy) begin
        r_out_voice  <= r_cnt;
        r_out_phase  <= w_out_phase;
        r_out_wrap   <= w_out_wrap;
        r_out_active <= w_new_active;
      end
      if (w_busy && bus.sample_tick) r_overrun <= 1'b1;
    end
  end

  assign bus.busy          = w_busy;
  assign bus.sweep_voice   = r_cnt;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_voice     = r_out_voice;
  assign bus.wavetableAddr = r_out_phase[PHASE_W-1:IW];
  assign bus.interp        = r_out_phase[IW-1:0];
  assign bus.out_wrap      = r_out_wrap;
  assign bus.out_active    = r_out_active;
  assign bus.overrun       = r_overrun;
endmodule

// File: tb/tb_multi_phasor.sv
// Scoreboard bench for multi_phasor with default parameters.
// A reference model pushes expected beats at every tick; observed beats are queued.
// Each scenario task compares its own beats and spot values inline.
module tb_multi_phasor;
  localparam int N = 8;
  localparam int P = 32;
  localparam int A = 12;
  localparam int I = P - A;

  typedef struct packed {
    logic [2:0]   voice;
    logic [A-1:0] addr;
    logic [I-1:0] interp;
    logic         wrap;
    logic         active;
  } beat_t;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  multi_phasor_if #(.NUM_VOICES(N), .PHASE_W(P), .ADDR_W(A)) ifc ();
  multi_phasor #(.NUM_VOICES(N), .PHASE_W(P), .ADDR_W(A)) dut (.Clk(Clk), .Reset(Reset), .bus(ifc));

  int n_cmp  = 0;
  int n_fail = 0;

  logic [P-1:0] m_phase [N];
  logic [P-1:0] m_inc   [N];
  logic [1:0]   m_mode  [N];
  logic         m_act   [N];
  logic         m_pend  [N];
  beat_t exp_q[$];
  beat_t obs_q[$];
  beat_t sweep_obs [N];
  int    beats;

  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      m_phase[v] = '0; m_inc[v] = '0; m_mode[v] = 2'd0; m_act[v] = 1'b1; m_pend[v] = 1'b0;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic model_sweep(input logic [P-1:0] fm);
    logic prev_wrap = 1'b0;
    for (int v = 0; v < N; v++) begin
      logic signed [P:0] eff;
      logic [P-1:0] nxt, outp, nw;
      logic wrap;
      beat_t b;
      eff = $signed({1'b0, m_inc[v]}) + $signed({fm[P-1], fm});
      nxt = m_phase[v] + eff[P-1:0];
      if (m_pend[v]) begin
        outp = '0; wrap = 1'b0; nw = eff[P-1:0]; m_pend[v] = 1'b0; m_act[v] = 1'b1;
      end else if (!m_act[v]) begin
        outp = '0; wrap = 1'b0; nw = '0;
      end else begin
        outp = m_phase[v];
        wrap = (eff >= 0) ? (nxt < m_phase[v]) : (nxt > m_phase[v]);
        nw   = nxt;
        if (m_mode[v] == 2'd1 && wrap) begin
          nw = '0; m_act[v] = 1'b0;
        end else if (m_mode[v] == 2'd2 && v >= 1 && prev_wrap) begin
          nw = '0;
        end
      end
      b.voice = 3'(v); b.addr = outp[P-1:I]; b.interp = outp[I-1:0];
      b.wrap = wrap; b.active = m_act[v];
      exp_q.push_back(b);
      m_phase[v] = nw;
      prev_wrap = wrap;
    end
  endtask

  task automatic model_write(input int v, input logic [P-1:0] inc, input logic [1:0] mode);
    m_inc[v] = inc; m_mode[v] = mode;
    if (mode != 2'd1) m_act[v] = 1'b1;
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic do_write(input int v, input logic [P-1:0] inc, input logic [1:0] mode);
    ifc.wr_en = 1'b1; ifc.wr_voice = 3'(v); ifc.wr_inc = inc; ifc.wr_mode = mode;
    tick();
    ifc.wr_en = 1'b0;
    model_write(v, inc, mode);
  endtask

  task automatic do_trig(input int v);
    ifc.trig_en = 1'b1; ifc.trig_voice = 3'(v);
    tick();
    ifc.trig_en = 1'b0;
    m_pend[v] = 1'b1;
  endtask

  // One sweep: optional extra tick at loop step extra_at, trigger/write aimed at the voice in flight.
  task automatic run_sweep(input logic [P-1:0] fm, input int extra_at, input int trig_v,
                           input int wr_v, input logic [P-1:0] winc, input logic [1:0] wmode);
    int guard = 0;
    while (ifc.busy && guard < 50) begin tick(); guard++; end
    if (guard >= 50) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, want 0", ifc.busy, guard);
    end
    ifc.fm_in = fm;
    ifc.sample_tick = 1'b1;
    model_sweep(fm);
    beats = 0;
    for (int k = 0; k < N + 4; k++) begin
      tick();
      ifc.sample_tick = (k == extra_at);
      ifc.trig_en  = ifc.busy && trig_v >= 0 && ifc.sweep_voice == 3'(trig_v);
      ifc.trig_voice = 3'(trig_v);
      ifc.wr_en    = ifc.busy && wr_v >= 0 && ifc.sweep_voice == 3'(wr_v);
      ifc.wr_voice = 3'(wr_v); ifc.wr_inc = winc; ifc.wr_mode = wmode;
      if (ifc.out_valid) begin
        beat_t o;
        o.voice = ifc.out_voice; o.addr = ifc.wavetableAddr; o.interp = ifc.interp;
        o.wrap = ifc.out_wrap; o.active = ifc.out_active;
        obs_q.push_back(o);
        sweep_obs[ifc.out_voice] = o;
        beats++;
      end
    end
    ifc.sample_tick = 1'b0; ifc.trig_en = 1'b0; ifc.wr_en = 1'b0;
    if (trig_v >= 0) m_pend[trig_v] = 1'b1;
    if (wr_v >= 0) model_write(wr_v, winc, wmode);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    ifc.sample_tick = 1'b1;
    tick(); tick();
    n_cmp++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", ifc.busy); end
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ifc.out_valid); end
    n_cmp++; if (ifc.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", ifc.overrun); end
    n_cmp++; if (ifc.sweep_voice !== 3'd0) begin n_fail++; $display("FAIL reset_sweep_voice: got %0d want 0", ifc.sweep_voice); end
    n_cmp++;
    if ({ifc.out_voice, ifc.wavetableAddr, ifc.interp, ifc.out_wrap, ifc.out_active} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v%0d a%h i%h w%b act%b want all 0",
               ifc.out_voice, ifc.wavetableAddr, ifc.interp, ifc.out_wrap, ifc.out_active);
    end
    ifc.sample_tick = 1'b0;
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_free_run();
    do_reset();
    do_write(2, 32'h0010_0000, 2'd0);
    for (int s = 0; s < 3; s++) begin
      logic [A-1:0] ea;
      ea = A'(s);
      run_sweep('0, -1, -1, -1, '0, 2'd0);
      n_cmp++; if (beats != N) begin n_fail++; $display("FAIL free_run_beats: got %0d want %0d", beats, N); end
      n_cmp++;
      if (sweep_obs[2].addr !== ea || sweep_obs[2].interp !== '0 || sweep_obs[2].wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL free_run_v2 sweep%0d: got a%h i%h w%b want a%h i0 w0",
                 s, sweep_obs[2].addr, sweep_obs[2].interp, sweep_obs[2].wrap, ea);
      end
    end
    while (exp_q.size() > 0) begin
      beat_t e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL free_run_sb: missing beat, want %h", e); end
      else begin
        beat_t o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL free_run_sb: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [A-1:0] ea [3] = '{12'h000, 12'h800, 12'h000};
    logic         ew [3] = '{1'b0, 1'b1, 1'b0};
    do_reset();
    do_write(0, 32'h8000_0000, 2'd0);
    for (int s = 0; s < 3; s++) begin
      run_sweep('0, -1, -1, -1, '0, 2'd0);
      n_cmp++;
      if (sweep_obs[0].addr !== ea[s] || sweep_obs[0].wrap !== ew[s]) begin
        n_fail++;
        $display("FAIL wrap_v0 sweep%0d: got a%h w%b want a%h w%b",
                 s, sweep_obs[0].addr, sweep_obs[0].wrap, ea[s], ew[s]);
      end
    end
    while (exp_q.size() > 0) begin
      beat_t e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL wrap_sb: missing beat, want %h", e); end
      else begin
        beat_t o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL wrap_sb: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_one_shot();
    do_reset();
    do_write(1, 32'h8000_0000, 2'd1);
    for (int s = 0; s < 4; s++) run_sweep('0, -1, -1, -1, '0, 2'd0);
    n_cmp++;
    if (sweep_obs[1].addr !== 12'h000 || sweep_obs[1].active !== 1'b0 || sweep_obs[1].wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL one_shot_stopped: got a%h act%b w%b want a000 act0 w0",
               sweep_obs[1].addr, sweep_obs[1].active, sweep_obs[1].wrap);
    end
    do_trig(1);
    run_sweep('0, -1, -1, -1, '0, 2'd0);
    n_cmp++;
    if (sweep_obs[1].addr !== 12'h000 || sweep_obs[1].active !== 1'b1 || sweep_obs[1].wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL one_shot_trig: got a%h act%b w%b want a000 act1 w0",
               sweep_obs[1].addr, sweep_obs[1].active, sweep_obs[1].wrap);
    end
    run_sweep('0, -1, -1, -1, '0, 2'd0);
    n_cmp++;
    if (sweep_obs[1].addr !== 12'h800) begin
      n_fail++; $display("FAIL one_shot_rerun: got a%h want a800", sweep_obs[1].addr);
    end
    while (exp_q.size() > 0) begin
      beat_t e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL one_shot_sb: missing beat, want %h", e); end
      else begin
        beat_t o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL one_shot_sb: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_hard_sync();
    do_reset();
    do_write(0, 32'h4000_0000, 2'd0);
    do_write(1, 32'h0100_0000, 2'd2);
    for (int s = 0; s < 4; s++) run_sweep('0, -1, -1, -1, '0, 2'd0);
    n_cmp++;
    if (sweep_obs[0].wrap !== 1'b1 || sweep_obs[1].addr !== 12'h030) begin
      n_fail++;
      $display("FAIL hard_sync_pre: got v0w%b v1a%h want v0w1 v1a030", sweep_obs[0].wrap, sweep_obs[1].addr);
    end
    run_sweep('0, -1, -1, -1, '0, 2'd0);
    n_cmp++;
    if (sweep_obs[1].addr !== 12'h000) begin
      n_fail++; $display("FAIL hard_sync_zeroed: got a%h want a000", sweep_obs[1].addr);
    end
    while (exp_q.size() > 0) begin
      beat_t e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL hard_sync_sb: missing beat, want %h", e); end
      else begin
        beat_t o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL hard_sync_sb: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_neg_fm_overrun();
    do_reset();
    run_sweep(32'hFFF0_0000, -1, -1, -1, '0, 2'd0);
    n_cmp++;
    if (sweep_obs[0].addr !== 12'h000 || sweep_obs[0].wrap !== 1'b1) begin
      n_fail++; $display("FAIL neg_fm_first: got a%h w%b want a000 w1", sweep_obs[0].addr, sweep_obs[0].wrap);
    end
    n_cmp++;
    if (ifc.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b want 0", ifc.overrun); end
    run_sweep(32'hFFF0_0000, 3, -1, -1, '0, 2'd0);
    n_cmp++;
    if (sweep_obs[0].addr !== 12'hFFF) begin
      n_fail++; $display("FAIL neg_fm_addr: got a%h want aFFF", sweep_obs[0].addr);
    end
    n_cmp++;
    if (ifc.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", ifc.overrun); end
    n_cmp++;
    if (beats != N || ifc.busy !== 1'b0) begin
      n_fail++; $display("FAIL overrun_beats: got %0d busy%b want %0d busy0", beats, ifc.busy, N);
    end
    while (exp_q.size() > 0) begin
      beat_t e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL neg_fm_sb: missing beat, want %h", e); end
      else begin
        beat_t o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL neg_fm_sb: got %h want %h", o, e); end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL neg_fm_extra: got %0d extra beats want 0", obs_q.size()); end
  endtask

  // Trigger and write aimed at the voice currently being processed defer to the next sweep.
  task automatic test_back_to_back();
    do_reset();
    do_write(3, 32'h0010_0000, 2'd0);
    run_sweep('0, -1, 3, 4, 32'h0020_0000, 2'd0);
    run_sweep('0, -1, -1, -1, '0, 2'd0);
    n_cmp++;
    if (sweep_obs[3].addr !== 12'h000 || sweep_obs[4].addr !== 12'h000) begin
      n_fail++;
      $display("FAIL deferred_sweep2: got v3a%h v4a%h want a000 a000", sweep_obs[3].addr, sweep_obs[4].addr);
    end
    run_sweep('0, -1, -1, -1, '0, 2'd0);
    n_cmp++;
    if (sweep_obs[3].addr !== 12'h001 || sweep_obs[4].addr !== 12'h002) begin
      n_fail++;
      $display("FAIL deferred_sweep3: got v3a%h v4a%h want a001 a002", sweep_obs[3].addr, sweep_obs[4].addr);
    end
    while (exp_q.size() > 0) begin
      beat_t e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL back_to_back_sb: missing beat, want %h", e); end
      else begin
        beat_t o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL back_to_back_sb: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int guard = 0;
    do_reset();
    do_write(5, 32'h0010_0000, 2'd0);
    ifc.sample_tick = 1'b1;
    tick();
    ifc.sample_tick = 1'b0;
    while (!(ifc.busy && ifc.sweep_voice == 3'd3) && guard < 20) begin tick(); guard++; end
    n_cmp++;
    if (guard >= 20) begin n_fail++; $display("FAIL mid_sweep_reach: never saw voice 3, want voice 3"); end
    Reset = 1'b1;
    ifc.sample_tick = 1'b1;
    ifc.wr_en = 1'b1; ifc.wr_voice = 3'd5; ifc.wr_inc = 32'hFFFF_FFFF; ifc.wr_mode = 2'd1;
    ifc.trig_en = 1'b1; ifc.trig_voice = 3'd2;
    tick();
    n_cmp++;
    if (ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0 || ifc.sweep_voice !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_sweep_abort: got valid%b busy%b sv%0d want 0 0 0", ifc.out_valid, ifc.busy, ifc.sweep_voice);
    end
    n_cmp++;
    if ({ifc.out_voice, ifc.wavetableAddr, ifc.interp, ifc.out_wrap, ifc.out_active, ifc.overrun} !== '0) begin
      n_fail++;
      $display("FAIL mid_sweep_outputs: got v%0d a%h i%h w%b act%b ov%b want all 0", ifc.out_voice,
               ifc.wavetableAddr, ifc.interp, ifc.out_wrap, ifc.out_active, ifc.overrun);
    end
    Reset = 1'b0;
    ifc.sample_tick = 1'b0; ifc.wr_en = 1'b0; ifc.trig_en = 1'b0;
    model_reset();
    run_sweep('0, -1, -1, -1, '0, 2'd0);
    run_sweep('0, -1, -1, -1, '0, 2'd0);
    n_cmp++;
    if (sweep_obs[5].addr !== 12'h000 || sweep_obs[5].active !== 1'b1) begin
      n_fail++; $display("FAIL mid_sweep_inc_cleared: got a%h act%b want a000 act1", sweep_obs[5].addr, sweep_obs[5].active);
    end
    while (exp_q.size() > 0) begin
      beat_t e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL mid_sweep_sb: missing beat, want %h", e); end
      else begin
        beat_t o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL mid_sweep_sb: got %h want %h", o, e); end
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    ifc.sample_tick = 1'b0; ifc.fm_in = '0;
    ifc.wr_en = 1'b0; ifc.wr_voice = '0; ifc.wr_inc = '0; ifc.wr_mode = 2'd0;
    ifc.trig_en = 1'b0; ifc.trig_voice = '0;
    model_reset();
    test_reset();
    test_free_run();
    test_wrap();
    test_one_shot();
    test_hard_sync();
    test_neg_fm_overrun();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
